aes_seq_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_rnd_timer.sv | 45 ++++
 rtl/aes_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_aes_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and controller state encoding
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_BLOCK_W    = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_OUT       = 3'd5
    } aes_state_e;

endpackage

// File: rtl/aes_rnd_timer.sv
// rtl/aes_rnd_timer.sv - round prescaler and round index counter for the AES datapath
module aes_rnd_timer
    import aes_pkg::*;
#(
    parameter int ROUND_CYCLES = 4,
    parameter int NUM_ROUNDS   = AES_NUM_ROUNDS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       run,
    output logic [3:0] rnd,
    output logic       rounds_done
);

    logic [3:0] pre_cnt_q;
    logic [3:0] rnd_q;
    logic       tick;

    assign tick = (pre_cnt_q == 4'(ROUND_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= 4'd0;
            rnd_q     <= 4'd0;
        end else if (start) begin
            pre_cnt_q <= 4'd0;
            rnd_q     <= 4'd1;
        end else if (run) begin
            if (tick) begin
                pre_cnt_q <= 4'd0;
                // Final round index is held once reached.
                if (rnd_q != 4'(NUM_ROUNDS)) begin
                    rnd_q <= rnd_q + 4'd1;
                end
            end else begin
                pre_cnt_q <= pre_cnt_q + 4'd1;
            end
        end
    end

    assign rnd         = rnd_q;
    assign rounds_done = run && tick && (rnd_q == 4'(NUM_ROUNDS));

endmodule

// File: rtl/aes_seq_ctrl.sv
// rtl/aes_seq_ctrl.sv - AES-128 datapath sequencer with in/out handshakes and watchdog
module aes_seq_ctrl
    import aes_pkg::*;
#(
    parameter int INIT_CYCLES  = 3,
    parameter int ROUND_CYCLES = 4,
    parameter int NUM_ROUNDS   = AES_NUM_ROUNDS,
    parameter int TIMEOUT      = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_plain,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_cipher,
    output logic         err,
    output logic         dp_init,
    output logic         dp_ctrl1,
    output logic         dp_ctrl2,
    output logic         dp_ctrl3,
    output logic [3:0]   dp_rnd,
    output logic [127:0] dp_plain_text,
    output logic [127:0] dp_key,
    input  logic         dp_done,
    input  logic [127:0] dp_cipher_text
);

    aes_state_e state_q, state_d;
    logic [3:0] init_cnt_q;
    logic [7:0] wd_cnt_q;
    aes_block_t plain_q, key_q, cipher_q;
    logic       err_q;
    logic [3:0] timer_rnd;
    logic       rounds_done;
    logic       busy, accept, done_hit, init_last, wd_expired;

    assign busy       = (state_q == ST_RUN) || (state_q == ST_WAIT_DONE);
    assign accept     = (state_q == ST_IDLE) && in_valid;
    assign done_hit   = busy && dp_done;
    assign init_last  = (init_cnt_q == 4'(INIT_CYCLES - 1));
    assign wd_expired = (wd_cnt_q == 8'(TIMEOUT - 1));

    aes_rnd_timer #(
        .ROUND_CYCLES (ROUND_CYCLES),
        .NUM_ROUNDS   (NUM_ROUNDS)
    ) u_rnd_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (state_q == ST_LOAD),
        .run         (state_q == ST_RUN),
        .rnd         (timer_rnd),
        .rounds_done (rounds_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // dp_done takes priority over the watchdog when both land on one edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (in_valid) state_d = ST_INIT;
            ST_INIT:      if (init_last) state_d = ST_LOAD;
            ST_LOAD:      state_d = ST_RUN;
            ST_RUN: begin
                if (dp_done)          state_d = ST_OUT;
                else if (wd_expired)  state_d = ST_IDLE;
                else if (rounds_done) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (dp_done)         state_d = ST_OUT;
                else if (wd_expired) state_d = ST_IDLE;
            end
            ST_OUT:       if (out_ready) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dp_init   = 1'b0;
        dp_ctrl1  = 1'b0;
        dp_ctrl2  = 1'b0;
        dp_ctrl3  = 1'b0;
        dp_rnd    = 4'd0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_INIT: dp_init  = 1'b1;
            ST_LOAD: begin
                dp_ctrl1 = 1'b1;
                dp_ctrl2 = 1'b1;
                dp_ctrl3 = 1'b1;
                dp_rnd   = 4'd1;
            end
            ST_RUN, ST_WAIT_DONE: dp_rnd = timer_rnd;
            ST_OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_q <= 4'd0;
            wd_cnt_q   <= 8'd0;
            plain_q    <= '0;
            key_q      <= '0;
            cipher_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                init_cnt_q <= 4'd0;
            end else if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + 4'd1;
            end

            if (state_q == ST_LOAD) begin
                wd_cnt_q <= 8'd0;
            end else if (busy) begin
                wd_cnt_q <= wd_cnt_q + 8'd1;
            end

            if (accept) begin
                plain_q <= in_plain;
                key_q   <= in_key;
                err_q   <= 1'b0;
            end else if (busy && !dp_done && wd_expired) begin
                err_q   <= 1'b1;
            end

            if (done_hit) begin
                cipher_q <= dp_cipher_text;
            end
        end
    end

    assign dp_plain_text = plain_q;
    assign dp_key        = key_q;
    assign out_cipher    = cipher_q;
    assign err           = err_q;

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// tb/tb_aes_seq_ctrl.sv - randomized self-checking bench for aes_seq_ctrl against a timeline model
module tb_aes_seq_ctrl;
    import aes_pkg::*;

    localparam int INIT_CYCLES  = 3;
    localparam int ROUND_CYCLES = 4;
    localparam int NUM_ROUNDS   = 10;
    localparam int TIMEOUT      = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, err;
    logic       dp_init, dp_ctrl1, dp_ctrl2, dp_ctrl3, dp_done;
    logic [3:0] dp_rnd;
    aes_block_t in_plain, in_key, out_cipher, dp_plain_text, dp_key, dp_cipher_text;

    always #5 clk = ~clk;

    aes_seq_ctrl #(
        .INIT_CYCLES  (INIT_CYCLES),
        .ROUND_CYCLES (ROUND_CYCLES),
        .NUM_ROUNDS   (NUM_ROUNDS),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_plain       (in_plain),
        .in_key         (in_key),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_cipher     (out_cipher),
        .err            (err),
        .dp_init        (dp_init),
        .dp_ctrl1       (dp_ctrl1),
        .dp_ctrl2       (dp_ctrl2),
        .dp_ctrl3       (dp_ctrl3),
        .dp_rnd         (dp_rnd),
        .dp_plain_text  (dp_plain_text),
        .dp_key         (dp_key),
        .dp_done        (dp_done),
        .dp_cipher_text (dp_cipher_text)
    );

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 sequencing (m_t = cycles since accept, first INIT cycle is 1), 2 output.
    int         m_mode;
    int         m_t;
    aes_block_t m_plain, m_key, m_cipher;
    logic       m_err;

    logic       s_valid, s_ready, s_done;
    aes_block_t s_plain, s_key, s_ct;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_rnd();
        int r;
        if (m_mode != 1 || m_t <= INIT_CYCLES) return 0;
        if (m_t == INIT_CYCLES + 1) return 1;
        r = 1 + (m_t - INIT_CYCLES - 2) / ROUND_CYCLES;
        return (r > NUM_ROUNDS) ? NUM_ROUNDS : r;
    endfunction

    function automatic aes_block_t rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_outputs();
        logic e_init, e_load;
        e_init = (m_mode == 1) && (m_t <= INIT_CYCLES);
        e_load = (m_mode == 1) && (m_t == INIT_CYCLES + 1);
        check("in_ready",  128'(in_ready),  128'(m_mode == 0));
        check("out_valid", 128'(out_valid), 128'(m_mode == 2));
        check("err",       128'(err),       128'(m_err));
        check("dp_init",   128'(dp_init),   128'(e_init));
        check("dp_ctrl1",  128'(dp_ctrl1),  128'(e_load));
        check("dp_ctrl2",  128'(dp_ctrl2),  128'(e_load));
        check("dp_ctrl3",  128'(dp_ctrl3),  128'(e_load));
        check("dp_rnd",    128'(dp_rnd),    128'(model_rnd()));
        check("dp_plain",  dp_plain_text,   m_plain);
        check("dp_key",    dp_key,          m_key);
        check("out_cipher", out_cipher,     m_cipher);
    endtask

    // Called at a falling edge: check, drive this cycle's inputs, advance the model one edge.
    task automatic cycle();
        check_outputs();
        in_valid       = s_valid;
        in_plain       = s_plain;
        in_key         = s_key;
        out_ready      = s_ready;
        dp_done        = s_done;
        dp_cipher_text = s_ct;
        case (m_mode)
            0: if (s_valid) begin
                m_mode  = 1;
                m_t     = 1;
                m_plain = s_plain;
                m_key   = s_key;
                m_err   = 1'b0;
            end
            1: begin
                if (m_t > INIT_CYCLES + 1 && s_done) begin
                    m_mode   = 2;
                    m_cipher = s_ct;
                end else if (m_t == INIT_CYCLES + 1 + TIMEOUT) begin
                    m_mode = 0;
                    m_err  = 1'b1;
                end else begin
                    m_t++;
                end
            end
            default: if (s_ready) m_mode = 0;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_mode   = 0;
        m_t      = 0;
        m_plain  = '0;
        m_key    = '0;
        m_cipher = '0;
        m_err    = 1'b0;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic quiet_inputs();
        s_valid = 1'b0;
        s_ready = 1'b0;
        s_done  = 1'b0;
        s_plain = rand_block();
        s_key   = rand_block();
        s_ct    = rand_block();
    endtask

    task automatic run_until_rnd(input int target);
        int n = 0;
        while (!(m_mode == 1 && model_rnd() == target && m_t > INIT_CYCLES + 1) && n < 200) begin
            cycle();
            n++;
        end
        check("reach_rnd", 128'(model_rnd()), 128'(target));
    endtask

    initial begin
        in_valid = 1'b0; in_plain = '0; in_key = '0; out_ready = 1'b0;
        dp_done = 1'b0; dp_cipher_text = '0;
        quiet_inputs();
        do_reset();

        // Basic accept, dp_done ignored through INIT and LOAD, in_valid ignored while busy
        s_valid = 1'b1;
        s_plain = 128'h0011_2233_4455_6677_8899_aabb_1223_3445;
        s_key   = 128'hfeed_face_0102_0304_0506_0708_a392_8674;
        cycle();
        s_done = 1'b1;
        s_plain = rand_block();
        s_key   = rand_block();
        for (int i = 0; i < INIT_CYCLES + 1; i++) cycle();
        s_done = 1'b0;
        run_until_rnd(7);
        s_valid = 1'b0;
        s_done  = 1'b1;
        s_ct    = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
        cycle();
        s_done = 1'b0;

        // Backpressure for 20 cycles, then release
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        s_ready = 1'b1;
        s_valid = 1'b0;
        cycle();
        cycle();

        // Timeout: dp_done never arrives
        s_ready = 1'b0;
        s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
        for (int i = 0; i < INIT_CYCLES + 1 + TIMEOUT + 5; i++) cycle();
        check("timeout_err", 128'(err), 128'(1));
        s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
        cycle();

        // Async reset mid-run, then a clean full sequence through WAIT_DONE
        run_until_rnd(5);
        do_reset();
        s_valid = 1'b1;
        s_plain = rand_block();
        s_key   = rand_block();
        cycle();
        s_valid = 1'b0;
        for (int i = 0; i < INIT_CYCLES + 1 + NUM_ROUNDS * ROUND_CYCLES + 3; i++) cycle();
        s_done = 1'b1;
        s_ct   = rand_block();
        cycle();
        s_done  = 1'b0;
        s_ready = 1'b1;
        cycle();
        cycle();

        // Randomized traffic; one stretch with no dp_done exercises the watchdog
        for (int blk = 0; blk < 6; blk++) begin
            int p;
            p = (blk == 3) ? 0 : int'($urandom_range(8, 40));
            for (int i = 0; i < 400; i++) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_ready = ($urandom_range(0, 1) != 0);
                s_done  = (p != 0) && ($urandom_range(1, p) == 1);
                s_plain = rand_block();
                s_key   = rand_block();
                s_ct    = rand_block();
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
